// File: rtl/fpchk_pkg.sv
// Shared types and helpers for the floating-point vector checker:
// FSM state encodings, the expectation FIFO entry layout and NaN detection.
package fpchk_pkg;

    // FSM state encodings.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Widest supported format; narrower formats are zero-extended into entries.
    localparam int MAX_W      = 64;
    localparam int MAX_FLAG_W = 8;

    // Legal WIDTH / EXP_W pairings (IEEE half, single, double).
    localparam int EXP_W_16 = 5;
    localparam int EXP_W_32 = 8;
    localparam int EXP_W_64 = 11;

    // Exponent width that belongs to a given operand width (0 if unsupported).
    function automatic int exp_w_for(input int width);
        case (width)
            16:      return EXP_W_16;
            32:      return EXP_W_32;
            64:      return EXP_W_64;
            default: return 0;
        endcase
    endfunction

    // One queued expectation: operands, expected result and expected flags.
    typedef struct packed {
        logic [MAX_W-1:0]      a;
        logic [MAX_W-1:0]      b;
        logic [MAX_W-1:0]      exp;
        logic [MAX_FLAG_W-1:0] flags;
    } fifo_entry_t;

    // NaN: exponent all ones and mantissa nonzero; the sign bit is ignored.
    function automatic logic is_nan(input logic [MAX_W-1:0] value,
                                    input int width, input int exp_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width - 1 - exp_w)
                man_nz = man_nz | value[i];
            else if (i < width - 1)
                exp_ones = exp_ones & value[i];
        end
        return exp_ones & man_nz;
    endfunction

endpackage

// File: rtl/fpchk_fifo.sv
// Synchronous FIFO holding in-flight expectations. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module fpchk_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards everything in flight.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; pointers alone define validity, so it maps to RAM.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fp_vector_checker.sv
// Vector harness for fpdiv/sqrt: issues operands to the DUT, queues the
// expectations in order and scores each DUT response against its expectation.
module fp_vector_checker
    import fpchk_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_W     = 8,
    parameter int DEPTH     = 8,
    parameter int FLAG_W    = 5,    // up to MAX_FLAG_W
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1024,
    parameter int NAN_EQUIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              check_flags,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [WIDTH-1:0]  vec_a,
    input  logic [WIDTH-1:0]  vec_b,
    input  logic [WIDTH-1:0]  vec_exp,
    input  logic [FLAG_W-1:0] vec_flags,
    input  logic              vec_last,
    output logic              dut_req_valid,
    input  logic              dut_req_ready,
    output logic [WIDTH-1:0]  dut_a,
    output logic [WIDTH-1:0]  dut_b,
    input  logic              dut_rsp_valid,
    input  logic [WIDTH-1:0]  dut_rsp_q,
    input  logic [FLAG_W-1:0] dut_rsp_flags,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              mism_valid,
    output logic [WIDTH-1:0]  mism_a,
    output logic [WIDTH-1:0]  mism_b,
    output logic [WIDTH-1:0]  mism_got,
    output logic [WIDTH-1:0]  mism_exp,
    output logic              done,
    output logic              spurious_err,
    output logic              timeout_err
);

    localparam int         WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    state_t               state;
    logic                 in_run;
    logic                 busy;
    logic                 start_run;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [$clog2(DEPTH):0] occupancy;
    logic                 wd_expire;
    logic [WD_W-1:0]      wd_cnt;
    logic                 rsp_pass;
    fifo_entry_t          push_entry;
    fifo_entry_t          head;
    logic [MAX_W-1:0]     rsp_q_ext;

    assign in_run    = (state == ST_RUN);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign done      = (state == ST_DONE);

    // Issue path is a pure passthrough gated by state and FIFO space.
    assign dut_req_valid = vec_valid & in_run & ~full;
    assign vec_ready     = dut_req_ready & in_run & ~full;
    assign dut_a         = vec_a;
    assign dut_b         = vec_b;
    assign push          = vec_valid & vec_ready;
    assign pop           = dut_rsp_valid & ~empty;

    assign wd_expire = busy && !empty && !dut_rsp_valid && (wd_cnt == WD_LAST);
    assign rsp_q_ext = MAX_W'(dut_rsp_q);

    // Pack the accepted vector into a FIFO entry.
    always_comb begin
        // NOTE: assign a default first so no path leaves bits holding old values (latch).
        push_entry       = '0;
        push_entry.a     = MAX_W'(vec_a);
        push_entry.b     = MAX_W'(vec_b);
        push_entry.exp   = MAX_W'(vec_exp);
        push_entry.flags = MAX_FLAG_W'(vec_flags);
    end

    fpchk_fifo #(
        .DATA_W ($bits(fifo_entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (start_run | wd_expire),
        .push   (push),
        .pop    (pop),
        .wdata  (push_entry),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (occupancy)
    );

    // Compare the DUT response with the head expectation.
    always_comb begin
        logic val_eq;
        logic nan_eq;
        logic flags_eq;
        val_eq   = (head.exp == rsp_q_ext);
        nan_eq   = (NAN_EQUIV != 0) && is_nan(head.exp, WIDTH, EXP_W)
                   && is_nan(rsp_q_ext, WIDTH, EXP_W);
        flags_eq = !check_flags || (head.flags == MAX_FLAG_W'(dut_rsp_flags));
        rsp_pass = (val_eq || nan_eq) && flags_eq;
    end

    // Run-control FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
                ST_RUN: begin
                    if (wd_expire)            state <= ST_DONE;
                    else if (push && vec_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Empty only after the final pop has been scored.
                    if (wd_expire || empty)   state <= ST_DONE;
                end
                default:                      state <= ST_IDLE;
            endcase
        end
    end

    // Watchdog: counts cycles with work outstanding and no response.
    always_ff @(posedge clk) begin
        if (!reset || !busy || empty || dut_rsp_valid)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_ONE;
    end

    // Scoreboard state: saturating counters, first-mismatch capture, sticky errors.
    always_ff @(posedge clk) begin
        if (!reset || start_run) begin
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            mism_valid   <= 1'b0;
            mism_a       <= '0;
            mism_b       <= '0;
            mism_got     <= '0;
            mism_exp     <= '0;
            spurious_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (pop) begin
                if (rsp_pass) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
                    if (!mism_valid) begin
                        mism_valid <= 1'b1;
                        mism_a     <= head.a[WIDTH-1:0];
                        mism_b     <= head.b[WIDTH-1:0];
                        mism_got   <= dut_rsp_q;
                        mism_exp   <= head.exp[WIDTH-1:0];
                    end
                end
            end
            if (dut_rsp_valid && empty) spurious_err <= 1'b1;
            if (wd_expire)              timeout_err  <= 1'b1;
        end
    end

endmodule

// File: doc/fp_vector_checker.md
Name: fp_vector_checker

Overview:
- Synthesizable, self-checking vector harness for the floating-point arithmetic units (fpdiv and its sqrt mode).
- Accepts a stream of test vectors {a, b, expected result, expected flags} and issues operands to the DUT over a valid/ready request channel.
- Queues expectations in order, compares each DUT response against its expectation, and keeps pass/fail counts.
- Successor to the file-driven div bench: parametrised in width and in-flight depth, with pipelined-DUT support, NaN-equivalence, flag checking, a watchdog and first-mismatch capture.

Parameters:
- WIDTH, 32: operand/result width; 16, 32 or 64 only.
- EXP_W, 8: exponent field width (5/8/11 to match WIDTH).
- DEPTH, 8: expectation FIFO depth (max operations in flight); power of two, >= 2.
- FLAG_W, 5: exception flag width.
- CNT_W, 32: pass/fail counter width.
- TIMEOUT, 1024: watchdog limit in cycles with ops in flight and no response.
- NAN_EQUIV, 1: 1 = any NaN result matches any NaN expectation.

Ports:
- clk in 1: clock.
- reset in 1: reset, synchronous, active-low.
- start in 1: begin a run; clears counters and errors.
- check_flags in 1: 1 = flags participate in the compare.
- vec_valid in 1: vector present.
- vec_ready out 1: vector accepted when valid&&ready.
- vec_a, vec_b in WIDTH: operands.
- vec_exp in WIDTH: expected result.
- vec_flags in FLAG_W: expected flags.
- vec_last in 1: final vector of the run.
- dut_req_valid out 1: request to DUT.
- dut_req_ready in 1: DUT accepts request.
- dut_a, dut_b out WIDTH: operands to DUT.
- dut_rsp_valid in 1: DUT result strobe (no backpressure).
- dut_rsp_q in WIDTH: DUT result.
- dut_rsp_flags in FLAG_W: DUT flags.
- pass_cnt, fail_cnt out CNT_W: counters.
- mism_valid out 1: first mismatch captured.
- mism_a, mism_b, mism_got, mism_exp out WIDTH: captured mismatch.
- done out 1: run complete.
- spurious_err out 1: response arrived with nothing in flight.
- timeout_err out 1: watchdog expired.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, FIFO emptied. All outputs 0: counters, mism_*, done, errors, vec_ready, dut_req_valid. Applies mid-run; in-flight expectations are discarded.
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. Entering RUN clears counters, mism_*, errors and done.
  - RUN --(accepted vector with vec_last)--> DRAIN.
  - DRAIN --(FIFO empty)--> DONE.
  - RUN/DRAIN --timeout--> DONE.
  - start is ignored in RUN/DRAIN.
- Issue path (combinational passthrough):
  - dut_req_valid = vec_valid & (state==RUN) & ~full.
  - vec_ready = dut_req_ready & (state==RUN) & ~full.
  - dut_a/dut_b = vec_a/vec_b.
  - On handshake, push {a, b, exp, flags} to the FIFO.
- Full rule: push is blocked when full, even if a pop occurs the same cycle. Simultaneous push and pop when not full leaves the occupancy unchanged.
- Response path:
  - On dut_rsp_valid with FIFO non-empty: pop the head and compare.
  - Result is registered: pass_cnt or fail_cnt increments on the cycle after dut_rsp_valid.
  - With FIFO empty: set sticky spurious_err; counters unchanged.
- Compare rules:
  - Match = bit-exact equality, so +0 and -0 differ.
  - If NAN_EQUIV=1 and both values are NaN (exponent all ones, mantissa nonzero), they match regardless of payload or sign.
  - If check_flags=1, flags must also be equal.
- Counters saturate at all ones.
- First mismatch loads mism_* and sets mism_valid. Later mismatches do not overwrite it until the next start.
- Watchdog counter:
  - Increments while the FIFO is non-empty and no response arrives.
  - Clears on any response or when the FIFO is empty.
  - Reaching TIMEOUT sets timeout_err and moves to DONE; the FIFO is flushed.
- done = (state==DONE), and stays high until start or reset.
- DRAIN to DONE occurs the cycle after the final pop is registered, so the counters are final when done rises.

Decomposition:
- Package fpchk_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - FIFO entry struct typedef.
  - function is_nan(value, width, exp_w).
  - Legal WIDTH/EXP_W pairs as constants.
- Sub-module fpchk_fifo:
  - Parametrised synchronous FIFO, DEPTH entries.
  - Outputs full, empty and occupancy.
  - Pointers are log2(DEPTH)+1 bits wide and wrap around.

Test Plan:
- Single op, WIDTH=32: start, vector 3f800000/40000000, exp 3f000000; DUT answers 3f000000 after 4 cycles -> pass_cnt=1, fail_cnt=0; vec_last set so done=1.
- Pipelined DUT, DEPTH=8: 12 back-to-back vectors, 10-cycle DUT latency -> vec_ready drops after 8 accepts; all 12 pass; FIFO never exceeds 8.
- Mismatches: exp 40490fdb, DUT returns 40490fda, then a second mismatch -> fail_cnt=2; mism_got=40490fda, mism_exp=40490fdb (first mismatch retained).
- NaN and zero sign: exp 7fc00000, got ffc00001 -> pass with NAN_EQUIV=1, fail with 0. exp 00000000, got 80000000 -> fail.
- Flags: result correct, flags 00001 vs 00000 -> fail if check_flags=1, pass if 0.
- Errors and reset:
  - dut_rsp_valid with empty FIFO -> spurious_err=1, counters 0.
  - DUT silent after issue, TIMEOUT=16 -> timeout_err after 16 cycles, done=1.
  - reset low mid-run -> all outputs 0 on the next edge.
